uart_kbd_matrix: RTL



---
 rtl/pet_kbd_pkg.sv | 115 +++++++++++
 rtl/pet_ascii_keymap.sv | 28 ++
 rtl/uart_kbd_matrix.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/pet_kbd_pkg.sv
// Shared PET 2001 keyboard matrix definitions and the ASCII-to-matrix table.
package pet_kbd_pkg;

    localparam int KBD_ROWS  = 10;
    localparam int KBD_COLS  = 8;
    localparam int SHIFT_ROW = 8;
    localparam int SHIFT_COL = 0;

    // One matrix position, plus whether the character needs SHIFT held with it.
    typedef struct packed {
        logic       hit;
        logic       shift;
        logic [3:0] row;
        logic [2:0] col;
    } kbd_entry_t;

    function automatic kbd_entry_t mk_key(input logic sh, input int r, input int c);
        kbd_entry_t e;
        e.hit   = 1'b1;
        e.shift = sh;
        e.row   = 4'(r);
        e.col   = 3'(c);
        return e;
    endfunction

    // Upper-case ASCII (and a few control codes) to graphics-keyboard position.
    function automatic kbd_entry_t ascii_to_key(input logic [7:0] ch);
        kbd_entry_t e;
        e = '0;
        case (ch)
            // row 0: ! # % & ( <- HOME RIGHT
            8'h21: e = mk_key(1'b0, 0, 0);
            8'h23: e = mk_key(1'b0, 0, 1);
            8'h25: e = mk_key(1'b0, 0, 2);
            8'h26: e = mk_key(1'b0, 0, 3);
            8'h28: e = mk_key(1'b0, 0, 4);
            8'h5F: e = mk_key(1'b0, 0, 5);
            8'h0C: e = mk_key(1'b1, 0, 6); // shifted HOME clears the screen
            // row 1: " $ ' \ ) - DOWN DEL
            8'h22: e = mk_key(1'b0, 1, 0);
            8'h24: e = mk_key(1'b0, 1, 1);
            8'h27: e = mk_key(1'b0, 1, 2);
            8'h5C: e = mk_key(1'b0, 1, 3);
            8'h29: e = mk_key(1'b0, 1, 4);
            8'h08: e = mk_key(1'b0, 1, 7);
            8'h7F: e = mk_key(1'b0, 1, 7);
            // row 2: Q E T U O ^ 7 9
            8'h51: e = mk_key(1'b0, 2, 0);
            8'h45: e = mk_key(1'b0, 2, 1);
            8'h54: e = mk_key(1'b0, 2, 2);
            8'h55: e = mk_key(1'b0, 2, 3);
            8'h4F: e = mk_key(1'b0, 2, 4);
            8'h5E: e = mk_key(1'b0, 2, 5);
            8'h37: e = mk_key(1'b0, 2, 6);
            8'h39: e = mk_key(1'b0, 2, 7);
            // row 3: W R Y I P - 8 /
            8'h57: e = mk_key(1'b0, 3, 0);
            8'h52: e = mk_key(1'b0, 3, 1);
            8'h59: e = mk_key(1'b0, 3, 2);
            8'h49: e = mk_key(1'b0, 3, 3);
            8'h50: e = mk_key(1'b0, 3, 4);
            8'h38: e = mk_key(1'b0, 3, 6);
            8'h2F: e = mk_key(1'b0, 3, 7);
            // row 4: A D G J L - 4 6
            8'h41: e = mk_key(1'b0, 4, 0);
            8'h44: e = mk_key(1'b0, 4, 1);
            8'h47: e = mk_key(1'b0, 4, 2);
            8'h4A: e = mk_key(1'b0, 4, 3);
            8'h4C: e = mk_key(1'b0, 4, 4);
            8'h34: e = mk_key(1'b0, 4, 6);
            8'h36: e = mk_key(1'b0, 4, 7);
            // row 5: S F H K : - 5 *
            8'h53: e = mk_key(1'b0, 5, 0);
            8'h46: e = mk_key(1'b0, 5, 1);
            8'h48: e = mk_key(1'b0, 5, 2);
            8'h4B: e = mk_key(1'b0, 5, 3);
            8'h3A: e = mk_key(1'b0, 5, 4);
            8'h35: e = mk_key(1'b0, 5, 6);
            8'h2A: e = mk_key(1'b0, 5, 7);
            // row 6: Z C B M ; RETURN 1 3
            8'h5A: e = mk_key(1'b0, 6, 0);
            8'h43: e = mk_key(1'b0, 6, 1);
            8'h42: e = mk_key(1'b0, 6, 2);
            8'h4D: e = mk_key(1'b0, 6, 3);
            8'h3B: e = mk_key(1'b0, 6, 4);
            8'h0D: e = mk_key(1'b0, 6, 5);
            8'h31: e = mk_key(1'b0, 6, 6);
            8'h33: e = mk_key(1'b0, 6, 7);
            // row 7: X V N , ? - 2 +
            8'h58: e = mk_key(1'b0, 7, 0);
            8'h56: e = mk_key(1'b0, 7, 1);
            8'h4E: e = mk_key(1'b0, 7, 2);
            8'h2C: e = mk_key(1'b0, 7, 3);
            8'h3F: e = mk_key(1'b0, 7, 4);
            8'h32: e = mk_key(1'b0, 7, 6);
            8'h2B: e = mk_key(1'b0, 7, 7);
            // row 8: LSHIFT @ ] - > RSHIFT 0 -
            8'h40: e = mk_key(1'b0, 8, 1);
            8'h5D: e = mk_key(1'b0, 8, 2);
            8'h3E: e = mk_key(1'b0, 8, 4);
            8'h30: e = mk_key(1'b0, 8, 6);
            8'h2D: e = mk_key(1'b0, 8, 7);
            // row 9: RVS [ SPACE < STOP - . =
            8'h5B: e = mk_key(1'b0, 9, 1);
            8'h20: e = mk_key(1'b0, 9, 2);
            8'h3C: e = mk_key(1'b0, 9, 3);
            8'h03: e = mk_key(1'b0, 9, 4);
            8'h2E: e = mk_key(1'b0, 9, 6);
            8'h3D: e = mk_key(1'b0, 9, 7);
            default: e = '0;
        endcase
        return e;
    endfunction

endpackage

// File: rtl/pet_ascii_keymap.sv
// Combinational ASCII byte to PET keyboard matrix position lookup.
module pet_ascii_keymap
    import pet_kbd_pkg::*;
(
    input  logic [7:0] rx_byte_i,
    output logic       hit_o,
    output logic       shift_o,
    output logic [3:0] row_o,
    output logic [2:0] col_o
);

    logic [7:0] folded;
    kbd_entry_t entry;

    // Fold lower case onto upper case (graphics keyboard has no case), then look up.
    always_comb begin
        folded = rx_byte_i;
        if (rx_byte_i >= 8'h61 && rx_byte_i <= 8'h7A) begin
            folded = rx_byte_i - 8'h20;
        end
        entry   = ascii_to_key(folded);
        hit_o   = entry.hit;
        shift_o = entry.shift;
        row_o   = entry.row;
        col_o   = entry.col;
    end

endmodule

// File: rtl/uart_kbd_matrix.sv
// Replays received ASCII bytes as timed key presses on an emulated PET matrix.
module uart_kbd_matrix
    import pet_kbd_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES       = 1500000,
    parameter int unsigned GAP_CYCLES        = 1500000,
    parameter int unsigned SHIFT_LEAD_CYCLES = 250000
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic [7:0] RX_DATA,
    input  logic       RX_VALID,
    output logic       RX_READY,
    input  logic [3:0] ROW_SEL,
    output logic [7:0] COL_OUT_N,
    output logic       BUSY,
    output logic       DROPPED
);

    // All three durations must be at least 1 cycle.
    localparam int unsigned MAX_HG  = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int unsigned MAX_CYC = (MAX_HG > SHIFT_LEAD_CYCLES) ? MAX_HG : SHIFT_LEAD_CYCLES;
    localparam int          CNT_W   = $clog2(MAX_CYC) + 1;

    localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] LEAD_LD = CNT_W'(SHIFT_LEAD_CYCLES - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LEAD  = 2'd1;
    localparam logic [1:0] ST_PRESS = 2'd2;
    localparam logic [1:0] ST_GAP   = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       key_row_q, key_row_d;
    logic [2:0]       key_col_q, key_col_d;
    logic             key_shift_q, key_shift_d;
    logic             rx_ready_q, rx_ready_d;
    logic             dropped_q, dropped_d;

    logic             map_hit, map_shift;
    logic [3:0]       map_row;
    logic [2:0]       map_col;
    logic             accept;
    logic             main_on, shift_on;
    logic [KBD_COLS-1:0] col_n;

    pet_ascii_keymap u_keymap (
        .rx_byte_i (RX_DATA),
        .hit_o     (map_hit),
        .shift_o   (map_shift),
        .row_o     (map_row),
        .col_o     (map_col)
    );

    assign accept = RX_VALID & rx_ready_q;

    // Next-state logic: accept/drop in IDLE, then count through lead, press and gap.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        key_row_d   = key_row_q;
        key_col_d   = key_col_q;
        key_shift_d = key_shift_q;
        dropped_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (map_hit) begin
                        key_row_d   = map_row;
                        key_col_d   = map_col;
                        key_shift_d = map_shift;
                        if (map_shift) begin
                            state_d = ST_LEAD;
                            cnt_d   = LEAD_LD;
                        end else begin
                            state_d = ST_PRESS;
                            cnt_d   = HOLD_LD;
                        end
                    end else begin
                        dropped_d = 1'b1;
                    end
                end
            end
            ST_LEAD: begin
                if (cnt_q == '0) begin
                    state_d = ST_PRESS;
                    cnt_d   = HOLD_LD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_PRESS: begin
                if (cnt_q == '0) begin
                    state_d = ST_GAP;
                    cnt_d   = GAP_LD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
        endcase
        rx_ready_d = (state_d == ST_IDLE);
    end

    // State, counter and latched key registers; reset releases every key at once.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            key_row_q   <= '0;
            key_col_q   <= '0;
            key_shift_q <= 1'b0;
            rx_ready_q  <= 1'b1;
            dropped_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            key_row_q   <= key_row_d;
            key_col_q   <= key_col_d;
            key_shift_q <= key_shift_d;
            rx_ready_q  <= rx_ready_d;
            dropped_q   <= dropped_d;
        end
    end

    assign main_on  = (state_q == ST_PRESS);
    assign shift_on = (state_q == ST_LEAD) | ((state_q == ST_PRESS) & key_shift_q);

    // Column read mux: pull low the bits of pressed keys in the row the PIA is scanning.
    always_comb begin
        col_n = '1;
        if (ROW_SEL < 4'(KBD_ROWS)) begin
            if (main_on && (ROW_SEL == key_row_q)) begin
                col_n[key_col_q] = 1'b0;
            end
            if (shift_on && (ROW_SEL == 4'(SHIFT_ROW))) begin
                col_n[SHIFT_COL] = 1'b0;
            end
        end
    end

    assign COL_OUT_N = col_n;
    assign RX_READY  = rx_ready_q;
    assign BUSY      = (state_q != ST_IDLE);
    assign DROPPED   = dropped_q;

endmodule
